// File: rtl/plab4_net_pkg.sv
// Shared types and port-index constants for the ring-router network slice.
package plab4_net_pkg;

    typedef logic [1:0] route_t;

    localparam route_t PORT_PREV = 2'd0;
    localparam route_t PORT_TERM = 2'd1;
    localparam route_t PORT_NEXT = 2'd2;

    localparam int HDR_DEST_NBITS = 3;

    typedef struct packed {
        logic [HDR_DEST_NBITS-1:0] dest;
        logic                      domain;
    } hdr_t;

    // What the input queue actually keeps per header: the precomputed route and the domain.
    typedef struct packed {
        route_t route;
        logic   domain;
    } entry_t;

endpackage

// File: rtl/plab4_net_route_compute_ring.sv
// Combinational ring routing: picks prev/terminal/next for a destination router id.
module plab4_net_route_compute_ring
    import plab4_net_pkg::*;
#(
    parameter int ROUTER_ID   = 0,
    parameter int NUM_ROUTERS = 8,
    parameter int DEST_NBITS  = 3
) (
    input  logic [DEST_NBITS-1:0] dest,
    output route_t                route
);

    localparam logic [DEST_NBITS:0] ID   = (DEST_NBITS+1)'(ROUTER_ID);
    localparam logic [DEST_NBITS:0] N    = (DEST_NBITS+1)'(NUM_ROUTERS);
    localparam logic [DEST_NBITS:0] HALF = (DEST_NBITS+1)'(NUM_ROUTERS / 2);

    logic [DEST_NBITS:0] dest_w;
    logic [DEST_NBITS:0] fwd;

    // One extra bit keeps dest + N from overflowing before the modular subtraction.
    always_comb begin
        dest_w = {1'b0, dest};
        if (dest_w >= ID) fwd = dest_w - ID;
        else              fwd = dest_w + N - ID;

        if (fwd == '0)        route = PORT_TERM;
        else if (fwd <= HALF) route = PORT_NEXT;
        else                  route = PORT_PREV;
    end

endmodule

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Router input-port control: header queue plus one-hot request/grant handshake.
// Optional domain filter enabled by PLAB4_NET_ROUTER_INCTRL_DOMAIN_FILTER_EN.
module plab4_net_router_input_ctrl_sep
    import plab4_net_pkg::*;
#(
    parameter int ROUTER_ID   = 0,
    parameter int NUM_ROUTERS = 8,
    parameter int DEST_NBITS  = 3,
    parameter int NUM_ENTRIES = 4
`ifdef PLAB4_NET_ROUTER_INCTRL_DOMAIN_FILTER_EN
  , parameter logic [7:0] SECURE_MASK = 8'h01
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [DEST_NBITS-1:0] in_dest,
    input  logic                  in_domain,
    output logic                  reqs_p0,
    output logic                  reqs_p1,
    output logic                  reqs_p2,
    output logic                  reqs_domain,
    input  logic                  grants_p0,
    input  logic                  grants_p1,
    input  logic                  grants_p2,
    output logic                  deq
`ifdef PLAB4_NET_ROUTER_INCTRL_DOMAIN_FILTER_EN
  , output logic                  drop_pulse
`endif
);

    localparam int PTR_NBITS = $clog2(NUM_ENTRIES);
    localparam int CNT_NBITS = PTR_NBITS + 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_REQ   = 1'b1;

    entry_t               queue_q [0:NUM_ENTRIES-1];
    logic [PTR_NBITS-1:0] head_q;
    logic [PTR_NBITS-1:0] tail_q;
    logic [CNT_NBITS-1:0] count_q;
    logic [CNT_NBITS-1:0] count_next;
    logic [0:0]           state_q;

    route_t in_route;
    entry_t head;
    logic   full;
    logic   accept;
    logic   enq;
    logic   drop;
    logic   req_valid;
    logic   granted;

    plab4_net_route_compute_ring #(
        .ROUTER_ID   (ROUTER_ID),
        .NUM_ROUTERS (NUM_ROUTERS),
        .DEST_NBITS  (DEST_NBITS)
    ) route_unit (
        .dest  (in_dest),
        .route (in_route)
    );

    // in_rdy is gated by the raw reset so it drops the instant reset asserts.
    always_comb begin
        full   = (count_q == CNT_NBITS'(NUM_ENTRIES));
        in_rdy = reset & ~full;
        accept = in_val & in_rdy;
`ifdef PLAB4_NET_ROUTER_INCTRL_DOMAIN_FILTER_EN
        drop   = accept & in_domain & ~SECURE_MASK[in_dest];
`else
        drop   = 1'b0;
`endif
        enq    = accept & ~drop;
    end

`ifdef PLAB4_NET_ROUTER_INCTRL_DOMAIN_FILTER_EN
    assign drop_pulse = drop;
`endif

    always_comb begin
        head        = queue_q[head_q];
        req_valid   = (state_q == ST_REQ);
        reqs_p0     = req_valid & (head.route == PORT_PREV);
        reqs_p1     = req_valid & (head.route == PORT_TERM);
        reqs_p2     = req_valid & (head.route == PORT_NEXT);
        reqs_domain = req_valid & head.domain;
        granted     = (reqs_p0 & grants_p0) | (reqs_p1 & grants_p1) | (reqs_p2 & grants_p2);
        deq         = granted;
        count_next  = count_q + CNT_NBITS'(enq) - CNT_NBITS'(granted);
    end

    always_ff @(posedge clk) begin
        if (enq) queue_q[tail_q] <= '{route: in_route, domain: in_domain};
    end

    // Pointers wrap naturally because NUM_ENTRIES is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_EMPTY;
        end else begin
            if (enq)     tail_q <= tail_q + 1'b1;
            if (granted) head_q <= head_q + 1'b1;
            count_q <= count_next;
            state_q <= (count_next != '0) ? ST_REQ : ST_EMPTY;
        end
    end

endmodule
